// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the three-way SDRAM access arbiter: FSM states,
// GRANT codes, rotation pointer values and the timeout read-data pattern.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_DISP = 2'd1;
  localparam logic [1:0] GNT_CAP  = 2'd2;
  localparam logic [1:0] GNT_MCS  = 2'd3;

  // Rotation pointer names the requester that currently has top priority.
  localparam logic [1:0] PTR_DISP = 2'd0;
  localparam logic [1:0] PTR_CAP  = 2'd1;
  localparam logic [1:0] PTR_MCS  = 2'd2;

  localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

  // Map a grant code to the one-hot ACK vector {mcs, cap, disp}.
  function automatic logic [2:0] gnt_to_ack(input logic [1:0] gnt);
    logic [2:0] ack;
    case (gnt)
      GNT_DISP: ack = 3'b001;
      GNT_CAP:  ack = 3'b010;
      GNT_MCS:  ack = 3'b100;
      default:  ack = 3'b000;
    endcase
    return ack;
  endfunction

endpackage

// File: rtl/sdram_arb_rr.sv
// Combinational rotating-priority picker for display, capture and MCS with an
// urgent override that forces the display to win whenever it is requesting.
module sdram_arb_rr
  import sdram_arb_pkg::*;
(
  input  logic [2:0] req,     // {mcs, cap, disp}
  input  logic       urgent,
  input  logic [1:0] ptr,
  output logic [2:0] win      // one-hot {mcs, cap, disp}
);

  // Winner selection: urgent display first, then round-robin from ptr.
  always_comb begin
    win = 3'b000;
    if (req[0] && urgent) begin
      win = 3'b001;
    end else begin
      case (ptr)
        PTR_CAP: begin
          if (req[1]) begin
            win = 3'b010;
          end else if (req[2]) begin
            win = 3'b100;
          end else if (req[0]) begin
            win = 3'b001;
          end else begin
            win = 3'b000;
          end
        end
        PTR_MCS: begin
          if (req[2]) begin
            win = 3'b100;
          end else if (req[0]) begin
            win = 3'b001;
          end else if (req[1]) begin
            win = 3'b010;
          end else begin
            win = 3'b000;
          end
        end
        default: begin
          if (req[0]) begin
            win = 3'b001;
          end else if (req[1]) begin
            win = 3'b010;
          end else if (req[2]) begin
            win = 3'b100;
          end else begin
            win = 3'b000;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Three-way arbiter sharing one SDRAM port between display, capture and MCS.
// Optional ISSUE watchdog enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W  = 21,
  parameter int TIMEOUT = 1023
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              DISP_REQ,
  input  logic              DISP_URGENT,
  input  logic [ADDR_W-1:0] DISP_ADDR,
  output logic              DISP_ACK,
  output logic [31:0]       DISP_RDATA,
  input  logic              CAP_REQ,
  input  logic [ADDR_W-1:0] CAP_ADDR,
  input  logic [31:0]       CAP_WDATA,
  output logic              CAP_ACK,
  input  logic              MCS_REQ,
  input  logic              MCS_WE,
  input  logic [ADDR_W-1:0] MCS_ADDR,
  input  logic [31:0]       MCS_WDATA,
  input  logic [3:0]        MCS_BE,
  output logic              MCS_ACK,
  output logic [31:0]       MCS_RDATA,
  output logic              MEM_REQ,
  output logic              MEM_WR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [31:0]       MEM_WDATA,
  output logic [3:0]        MEM_BE,
  input  logic              MEM_ACK,
  input  logic [31:0]       MEM_RDATA,
  output logic [1:0]        GRANT,
  output logic              ERR
);

  state_t              state_q, state_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          ptr_q, ptr_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [2:0]          ack_q, ack_d;
  logic [2:0]          req_s;
  logic [2:0]          win_s;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_ZERO = TMO_W'(0);

  logic [TMO_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
`endif

  assign req_s = {MCS_REQ, CAP_REQ, DISP_REQ};

  sdram_arb_rr u_rr (
    .req    (req_s),
    .urgent (DISP_URGENT),
    .ptr    (ptr_q),
    .win    (win_s)
  );

  // Next-state and latched transaction fields.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    rdata_d     = rdata_q;
    ack_d       = 3'b000;
`ifdef SDRAM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_s != 3'b000) begin
          state_d   = ST_ISSUE;
          mem_req_d = 1'b1;
`ifdef SDRAM_ARB_TIMEOUT_EN
          cnt_d     = TMO_ZERO;
`endif
          // The pointer moves past the winner, urgent grants included.
          case (win_s)
            3'b001: begin
              gnt_d       = GNT_DISP;
              ptr_d       = PTR_CAP;
              mem_wr_d    = 1'b0;
              mem_addr_d  = DISP_ADDR;
              mem_wdata_d = 32'h0000_0000;
              mem_be_d    = 4'hF;
            end
            3'b010: begin
              gnt_d       = GNT_CAP;
              ptr_d       = PTR_MCS;
              mem_wr_d    = 1'b1;
              mem_addr_d  = CAP_ADDR;
              mem_wdata_d = CAP_WDATA;
              mem_be_d    = 4'hF;
            end
            default: begin
              gnt_d       = GNT_MCS;
              ptr_d       = PTR_DISP;
              mem_wr_d    = MCS_WE;
              mem_addr_d  = MCS_ADDR;
              mem_wdata_d = MCS_WDATA;
              mem_be_d    = MCS_BE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (MEM_ACK) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          rdata_d   = MEM_RDATA;
          ack_d     = gnt_to_ack(gnt_q);
`ifdef SDRAM_ARB_TIMEOUT_EN
        end else if (cnt_q == TMO_LAST) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          rdata_d   = DEADBEEF;
          err_d     = 1'b1;
          ack_d     = gnt_to_ack(gnt_q);
        end else begin
          cnt_d = cnt_q + TMO_ONE;
        end
`else
        end else begin
          state_d = ST_ISSUE;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = GNT_NONE;
      end
      default: begin
        state_d   = ST_IDLE;
        gnt_d     = GNT_NONE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State, pointer and output registers; reset abandons any transaction.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      gnt_q       <= GNT_NONE;
      ptr_q       <= PTR_DISP;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= 32'h0000_0000;
      mem_be_q    <= 4'h0;
      rdata_q     <= 32'h0000_0000;
      ack_q       <= 3'b000;
`ifdef SDRAM_ARB_TIMEOUT_EN
      cnt_q       <= TMO_ZERO;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign MEM_REQ    = mem_req_q;
  assign MEM_WR     = mem_wr_q;
  assign MEM_ADDR   = mem_addr_q;
  assign MEM_WDATA  = mem_wdata_q;
  assign MEM_BE     = mem_be_q;
  assign GRANT      = gnt_q;
  assign DISP_ACK   = ack_q[0];
  assign CAP_ACK    = ack_q[1];
  assign MCS_ACK    = ack_q[2];
  assign DISP_RDATA = rdata_q;
  assign MCS_RDATA  = rdata_q;
`ifdef SDRAM_ARB_TIMEOUT_EN
  assign ERR        = err_q;
`else
  assign ERR        = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: the bench plays the memory interface and
// all three requesters, with hand-computed expectations.
module tb_sdram_arbiter;
  import sdram_arb_pkg::*;

  localparam int ADDR_W = 21;

  logic              CLK = 1'b0;
  logic              RST;
  logic              DISP_REQ, DISP_URGENT, DISP_ACK;
  logic [ADDR_W-1:0] DISP_ADDR;
  logic [31:0]       DISP_RDATA;
  logic              CAP_REQ, CAP_ACK;
  logic [ADDR_W-1:0] CAP_ADDR;
  logic [31:0]       CAP_WDATA;
  logic              MCS_REQ, MCS_WE, MCS_ACK;
  logic [ADDR_W-1:0] MCS_ADDR;
  logic [31:0]       MCS_WDATA, MCS_RDATA;
  logic [3:0]        MCS_BE;
  logic              MEM_REQ, MEM_WR, MEM_ACK;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [31:0]       MEM_WDATA, MEM_RDATA;
  logic [3:0]        MEM_BE;
  logic [1:0]        GRANT;
  logic              ERR;

  int n_chk  = 0;
  int n_pass = 0;
  int waited;

  sdram_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(15)) dut (
    .CLK(CLK), .RST(RST),
    .DISP_REQ(DISP_REQ), .DISP_URGENT(DISP_URGENT), .DISP_ADDR(DISP_ADDR),
    .DISP_ACK(DISP_ACK), .DISP_RDATA(DISP_RDATA),
    .CAP_REQ(CAP_REQ), .CAP_ADDR(CAP_ADDR), .CAP_WDATA(CAP_WDATA), .CAP_ACK(CAP_ACK),
    .MCS_REQ(MCS_REQ), .MCS_WE(MCS_WE), .MCS_ADDR(MCS_ADDR), .MCS_WDATA(MCS_WDATA),
    .MCS_BE(MCS_BE), .MCS_ACK(MCS_ACK), .MCS_RDATA(MCS_RDATA),
    .MEM_REQ(MEM_REQ), .MEM_WR(MEM_WR), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_BE(MEM_BE), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .GRANT(GRANT), .ERR(ERR)
  );

  always #10 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Wait (bounded) for MEM_REQ and check the owner; returns cycles waited.
  task automatic wait_req(input logic [1:0] exp_gnt, output int cycles);
    cycles = 0;
    while (!MEM_REQ && cycles < 20) begin
      step();
      cycles++;
    end
    check("mem_req_rise", {31'd0, MEM_REQ}, 32'd1);
    check("grant_issue", {30'd0, GRANT}, {30'd0, exp_gnt});
  endtask

  // Answer the outstanding request after lat cycles and check the ACK pulse.
  task automatic finish_txn(input logic [1:0] g, input int lat, input logic [31:0] rd);
    logic [2:0] exp_ack;
    for (int i = 1; i < lat; i++) step();
    check("grant_hold", {30'd0, GRANT}, {30'd0, g});
    check("no_early_ack", {29'd0, DISP_ACK, CAP_ACK, MCS_ACK}, 32'd0);
    MEM_ACK   = 1'b1;
    MEM_RDATA = rd;
    step();
    MEM_ACK   = 1'b0;
    MEM_RDATA = 32'h0;
    case (g)
      GNT_DISP: exp_ack = 3'b100;
      GNT_CAP:  exp_ack = 3'b010;
      GNT_MCS:  exp_ack = 3'b001;
      default:  exp_ack = 3'b000;
    endcase
    check("ack_pulse", {29'd0, DISP_ACK, CAP_ACK, MCS_ACK}, {29'd0, exp_ack});
    check("mem_req_drop", {31'd0, MEM_REQ}, 32'd0);
    if (g == GNT_DISP) check("disp_rdata", DISP_RDATA, rd);
    if (g == GNT_MCS)  check("mcs_rdata", MCS_RDATA, rd);
    step();
    check("ack_single", {29'd0, DISP_ACK, CAP_ACK, MCS_ACK}, 32'd0);
    check("grant_idle", {30'd0, GRANT}, 32'd0);
  endtask

  initial begin
    RST = 1'b1;
    DISP_REQ = 1'b0; DISP_URGENT = 1'b0; DISP_ADDR = '0;
    CAP_REQ = 1'b0; CAP_ADDR = '0; CAP_WDATA = 32'h0;
    MCS_REQ = 1'b0; MCS_WE = 1'b0; MCS_ADDR = '0; MCS_WDATA = 32'h0; MCS_BE = 4'h0;
    MEM_ACK = 1'b0; MEM_RDATA = 32'h0;
    step(); step();
    check("rst_mem_req", {31'd0, MEM_REQ}, 32'd0);
    check("rst_grant", {30'd0, GRANT}, 32'd0);
    check("rst_acks", {29'd0, DISP_ACK, CAP_ACK, MCS_ACK}, 32'd0);
    check("rst_rdata", DISP_RDATA | MCS_RDATA, 32'd0);
    check("rst_err", {31'd0, ERR}, 32'd0);
    RST = 1'b0;
    step();

    // Single MCS write.
    MCS_WE = 1'b1; MCS_ADDR = 21'h01234; MCS_WDATA = 32'hA5A5_5A5A; MCS_BE = 4'hF;
    MCS_REQ = 1'b1;
    wait_req(GNT_MCS, waited);
    check("mcs_req_latency", waited, 32'd1);
    check("mcs_wr", {31'd0, MEM_WR}, 32'd1);
    check("mcs_addr", {11'd0, MEM_ADDR}, 32'h0000_1234);
    check("mcs_wdata", MEM_WDATA, 32'hA5A5_5A5A);
    check("mcs_be", {28'd0, MEM_BE}, 32'hF);
    finish_txn(GNT_MCS, 4, 32'h0);
    MCS_REQ = 1'b0;

    // All three held: display, capture, MCS, display.
    DISP_ADDR = 21'h00F00;
    CAP_ADDR = 21'h1ABCD; CAP_WDATA = 32'h1357_9BDF;
    MCS_WE = 1'b0; MCS_ADDR = 21'h00055; MCS_BE = 4'h3;
    DISP_REQ = 1'b1; CAP_REQ = 1'b1; MCS_REQ = 1'b1;
    wait_req(GNT_DISP, waited);
    check("disp_wr", {31'd0, MEM_WR}, 32'd0);
    check("disp_addr", {11'd0, MEM_ADDR}, 32'h0000_0F00);
    finish_txn(GNT_DISP, 2, 32'h1111_0001);
    wait_req(GNT_CAP, waited);
    check("turnaround", waited, 32'd1);
    check("cap_wr", {31'd0, MEM_WR}, 32'd1);
    check("cap_addr", {11'd0, MEM_ADDR}, 32'h0001_ABCD);
    check("cap_wdata", MEM_WDATA, 32'h1357_9BDF);
    check("cap_be", {28'd0, MEM_BE}, 32'hF);
    finish_txn(GNT_CAP, 3, 32'h0);
    wait_req(GNT_MCS, waited);
    check("mcs_rd_wr", {31'd0, MEM_WR}, 32'd0);
    check("mcs_rd_be", {28'd0, MEM_BE}, 32'h3);
    finish_txn(GNT_MCS, 1, 32'h2222_0002);
    wait_req(GNT_DISP, waited);
    finish_txn(GNT_DISP, 2, 32'h3333_0003);
    DISP_REQ = 1'b0; CAP_REQ = 1'b0; MCS_REQ = 1'b0;

    // Urgent display beats capture even with display at lowest priority.
    CAP_REQ = 1'b1; DISP_REQ = 1'b1; DISP_URGENT = 1'b1;
    wait_req(GNT_DISP, waited);
    finish_txn(GNT_DISP, 2, 32'hCAFE_F00D);
    DISP_REQ = 1'b0; DISP_URGENT = 1'b0;
    wait_req(GNT_CAP, waited);
    finish_txn(GNT_CAP, 2, 32'h0);
    CAP_REQ = 1'b0;

    // Urgent arriving mid-capture does not preempt; it wins next over MCS.
    CAP_REQ = 1'b1;
    wait_req(GNT_CAP, waited);
    DISP_REQ = 1'b1; DISP_URGENT = 1'b1; MCS_REQ = 1'b1;
    step();
    check("no_preempt_grant", {30'd0, GRANT}, {30'd0, GNT_CAP});
    check("no_preempt_addr", {11'd0, MEM_ADDR}, 32'h0001_ABCD);
    finish_txn(GNT_CAP, 2, 32'h0);
    CAP_REQ = 1'b0;
    wait_req(GNT_DISP, waited);
    finish_txn(GNT_DISP, 2, 32'h4444_0004);
    DISP_REQ = 1'b0; DISP_URGENT = 1'b0;
    wait_req(GNT_MCS, waited);
    finish_txn(GNT_MCS, 2, 32'h5555_0005);
    MCS_REQ = 1'b0;

    // Stray MEM_ACK in IDLE is ignored.
    step();
    MEM_ACK = 1'b1;
    step();
    MEM_ACK = 1'b0;
    check("stray_acks", {29'd0, DISP_ACK, CAP_ACK, MCS_ACK}, 32'd0);
    check("stray_mem_req", {31'd0, MEM_REQ}, 32'd0);
    step();
    check("stray_grant", {30'd0, GRANT}, 32'd0);

    // Reset during ISSUE, then display regains top priority.
    DISP_REQ = 1'b1;
    wait_req(GNT_DISP, waited);
    step(); step();
    RST = 1'b1;
    #1;
    check("rst_mid_mem_req", {31'd0, MEM_REQ}, 32'd0);
    check("rst_mid_grant", {30'd0, GRANT}, 32'd0);
    check("rst_mid_addr", {11'd0, MEM_ADDR}, 32'd0);
    DISP_REQ = 1'b0;
    step();
    check("rst_mid_acks", {29'd0, DISP_ACK, CAP_ACK, MCS_ACK}, 32'd0);
    step();
    RST = 1'b0;
    step();
    check("post_rst_grant", {30'd0, GRANT}, 32'd0);
    check("post_rst_acks", {29'd0, DISP_ACK, CAP_ACK, MCS_ACK}, 32'd0);
    DISP_REQ = 1'b1; CAP_REQ = 1'b1; MCS_REQ = 1'b1;
    wait_req(GNT_DISP, waited);
    finish_txn(GNT_DISP, 2, 32'h6666_0006);
    DISP_REQ = 1'b0; CAP_REQ = 1'b0; MCS_REQ = 1'b0;
    step();

`ifdef SDRAM_ARB_TIMEOUT_EN
    // No MEM_ACK: abort after 15 ISSUE cycles with DEADBEEF and sticky ERR.
    MCS_WE = 1'b0;
    MCS_REQ = 1'b1;
    wait_req(GNT_MCS, waited);
    repeat (14) step();
    check("tmo_not_yet_ack", {31'd0, MCS_ACK}, 32'd0);
    check("tmo_not_yet_req", {31'd0, MEM_REQ}, 32'd1);
    check("tmo_not_yet_err", {31'd0, ERR}, 32'd0);
    step();
    check("tmo_ack", {31'd0, MCS_ACK}, 32'd1);
    check("tmo_rdata", MCS_RDATA, 32'hDEAD_BEEF);
    check("tmo_err", {31'd0, ERR}, 32'd1);
    check("tmo_req_drop", {31'd0, MEM_REQ}, 32'd0);
    MCS_REQ = 1'b0;
    step();
    check("tmo_ack_single", {31'd0, MCS_ACK}, 32'd0);
    CAP_REQ = 1'b1;
    wait_req(GNT_CAP, waited);
    finish_txn(GNT_CAP, 2, 32'h0);
    CAP_REQ = 1'b0;
    check("err_sticky", {31'd0, ERR}, 32'd1);
`else
    check("err_tied_low", {31'd0, ERR}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Three-way access arbiter in front of the SDRAM memory interface. It shares the single 32-bit read/write port between the VGA display reader, the camera capture writer and the MCS CPU bus, and replaces mode-register switching so all three can run concurrently. It issues one transaction at a time downstream, holds it until the memory interface signals completion, and returns the read data or completion pulse to the winning requester.

## Interface
Parameters:
- ADDR_W, 21, word address width, matches the memory interface address
- TIMEOUT, 1023, cycles `MEM_ACK` may be pending before abort; active only with `SDRAM_ARB_TIMEOUT_EN`

Ports:
- CLK  in  1  system clock, 50 MHz
- RST  in  1  reset, asynchronous, active-high
- DISP_REQ  in  1  display read request, level, held until `DISP_ACK`
- DISP_URGENT  in  1  display line FIFO below low watermark
- DISP_ADDR  in  ADDR_W  display read address
- DISP_ACK  out  1  one-cycle completion pulse
- DISP_RDATA  out  32  read data, valid while `DISP_ACK`=1
- CAP_REQ  in  1  capture write request, level
- CAP_ADDR  in  ADDR_W  capture write address
- CAP_WDATA  in  32  capture write data; byte enables are fixed at 4'hF
- CAP_ACK  out  1  one-cycle completion pulse
- MCS_REQ  in  1  CPU request, level
- MCS_WE  in  1  1 = write, 0 = read
- MCS_ADDR  in  ADDR_W  CPU address
- MCS_WDATA  in  32  CPU write data
- MCS_BE  in  4  CPU byte enables
- MCS_ACK  out  1  one-cycle completion pulse
- MCS_RDATA  out  32  read data, valid while `MCS_ACK`=1
- MEM_REQ  out  1  downstream request, level, held until `MEM_ACK`
- MEM_WR  out  1  downstream write flag
- MEM_ADDR  out  ADDR_W  latched address
- MEM_WDATA  out  32  latched write data
- MEM_BE  out  4  latched byte enables
- MEM_ACK  in  1  one-cycle done pulse from the memory interface
- MEM_RDATA  in  32  downstream read data, valid with `MEM_ACK`
- GRANT  out  2  current owner: 0 none, 1 display, 2 capture, 3 MCS
- ERR  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, ISSUE, DONE.
- **IDLE**
  - If any request is high, select a winner, latch its address, data, BE and WR, set `GRANT`, and go to ISSUE.
  - With no requests, stay in IDLE.
- **Winner selection**
  - `DISP_REQ`&`DISP_URGENT` always wins.
  - Otherwise use rotating priority over display, capture and MCS. The last granted requester has lowest priority; after reset the order is display > capture > MCS.
  - An urgent grant also updates the rotation pointer.
- **ISSUE**
  - `MEM_REQ`=1. Latched fields stay stable.
  - On `MEM_ACK`, capture `MEM_RDATA` into the read register and go to DONE.
- **DONE**
  - Assert the owner's `*_ACK` for exactly one cycle.
  - `DISP_RDATA` and `MCS_RDATA` both drive the read register.
  - Go to IDLE; `GRANT` returns to 0.
- **Requester rules**
  - A requester deasserts REQ on the clock edge ending its ACK cycle.
  - A REQ still high in IDLE is treated as a new request.
- **Preemption**
  - An in-flight transaction is never preempted.
  - `DISP_URGENT` only affects the next selection.
- **Stray ACK:** `MEM_ACK` outside ISSUE is ignored.
- **Reset:** all outputs 0, read register 0, state IDLE, rotation pointer to display.
  - Reset mid-transaction drops it without any ACK.
  - The memory interface is reset on the same `RST`.

## Timing
- A request sampled in IDLE at edge k gives `MEM_REQ`=1 from k+1.
- `MEM_ACK` at cycle m gives `*_ACK`=1 in cycle m+1 and IDLE in m+2.
- Minimum turnaround is 3 cycles plus memory latency, so the next `MEM_REQ` starts no earlier than m+3.
- All outputs are registered except `*_RDATA` and `GRANT`, which decode directly from registers.

## Configuration
- **`SDRAM_ARB_TIMEOUT_EN` defined:**
  - A counter clears on entry to ISSUE and increments each ISSUE cycle.
  - At TIMEOUT it sets `ERR` (sticky until `RST`), goes to DONE, and pulses the owner's ACK with read data 32'hDEADBEEF.
  - `MEM_REQ` drops at the same time.
- **Not defined:** ISSUE waits indefinitely, no counter is built, and `ERR` is tied to 0.

## Structure
- Package `sdram_arb_pkg`:
  - state encoding (IDLE, ISSUE, DONE)
  - grant codes (`GNT_NONE`, `GNT_DISP`, `GNT_CAP`, `GNT_MCS`)
  - `DEADBEEF` constant
- One sub-module, `sdram_arb_rr`: a combinational 3-input rotating-priority picker with urgent override.
  - Inputs: three requests, urgent, rotation pointer.
  - Output: a one-hot winner.
  - The pointer register lives in the parent.

## Test plan
- **Single MCS write:** `MCS_REQ`, `MCS_WE`=1, addr 0x01234, data 0xA5A55A5A, BE 0xF, `MEM_ACK` 4 cycles after `MEM_REQ` -> `MEM_*` fields match, `MCS_ACK` a single pulse 1 cycle after `MEM_ACK`, `GRANT`=3 during ISSUE.
- **All three request together, no urgent, held:** grants go display, capture, MCS, display…; each `*_ACK` fires once per transaction.
- **Urgent override:** rotation pointer at display (lowest), `CAP_REQ` and `DISP_REQ`+`DISP_URGENT` -> display granted next; in-flight capture completes first if already in ISSUE.
- **Display read:** `MEM_RDATA`=0xCAFEF00D with `MEM_ACK` -> `DISP_RDATA`=0xCAFEF00D while `DISP_ACK`=1.
- **Reset in ISSUE:** assert `RST` 2 cycles after `MEM_REQ` -> all outputs 0 immediately, no ACK, after release `GRANT`=0 and display has priority.
- **Timeout, macro on, TIMEOUT=15:** no `MEM_ACK` -> after 15 ISSUE cycles `ERR`=1, `MCS_ACK` pulses with `MCS_RDATA`=0xDEADBEEF, `ERR` stays 1 across later transactions.
